// File: rtl/sdram_pingpong_sched.sv
// Ping-pong frame scheduler for the sdram_mcb write/read command ports.
// A reader always gets the newest complete frame and never a buffer being written.
module sdram_pingpong_sched #(
    parameter logic [23:0] BUF_A_BASE = 24'h000000,
    parameter logic [23:0] BUF_B_BASE = 24'h008000,
    parameter logic [23:0] FRAME_LEN  = 24'h000800,
    parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_frame_req,
    output logic        wr_frame_ack,
    input  logic        rd_frame_req,
    output logic        rd_frame_ack,
    output logic        wr_load,
    output logic [23:0] wr_addr,
    output logic [23:0] wr_length,
    input  logic        wr_done,
    output logic        rd_load,
    output logic [23:0] rd_addr,
    output logic [23:0] rd_length,
    input  logic        rd_done,
    output logic        wr_buf_sel,
    output logic        rd_buf_sel,
    output logic        wr_stall,
    output logic [15:0] frame_cnt,
    output logic        wr_timeout,
    output logic        rd_timeout
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_LOAD = 2'd2;
    localparam logic [1:0] W_BUSY = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_LOAD = 2'd2;
    localparam logic [1:0] R_BUSY = 2'd3;

    logic [1:0]  wr_state;
    logic [1:0]  rd_state;
    logic        last_complete;
    logic        frame_valid;
    logic        rd_lock;
    logic        wr_target;
    logic [19:0] wr_tcnt;
    logic [19:0] rd_tcnt;

    logic wr_tmo;
    logic rd_tmo;
    logic rd_release;
    logic wr_conflict;
    logic wr_go;
    logic wr_sel_nxt;
    logic rd_go;

    assign wr_tmo     = (wr_tcnt == TIMEOUT - 20'd1);
    assign rd_tmo     = (rd_tcnt == TIMEOUT - 20'd1);
    assign rd_release = (rd_state == R_BUSY) && (rd_done || rd_tmo);

    // A write may not target the buffer a reader currently holds.
    assign wr_conflict = rd_lock && !rd_release && (rd_buf_sel == ~last_complete);
    assign wr_sel_nxt  = (wr_state == W_WAIT) ? wr_target : ~last_complete;
    assign wr_go = ((wr_state == W_IDLE) && wr_frame_req && !wr_conflict)
                || ((wr_state == W_WAIT) && (!rd_lock || rd_release));

    assign rd_go = ((rd_state == R_IDLE) && rd_frame_req && frame_valid)
                || ((rd_state == R_WAIT) && frame_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state      <= W_IDLE;
            wr_load       <= 1'b0;
            wr_frame_ack  <= 1'b0;
            wr_addr       <= 24'h0;
            wr_length     <= 24'h0;
            wr_buf_sel    <= 1'b0;
            wr_stall      <= 1'b0;
            wr_target     <= 1'b0;
            wr_tcnt       <= 20'h0;
            wr_timeout    <= 1'b0;
            frame_cnt     <= 16'h0;
            last_complete <= 1'b1;
            frame_valid   <= 1'b0;
        end else begin
            wr_load      <= 1'b0;
            wr_frame_ack <= 1'b0;
            if (wr_go) begin
                wr_state     <= W_LOAD;
                wr_load      <= 1'b1;
                wr_frame_ack <= 1'b1;
                wr_addr      <= wr_sel_nxt ? BUF_B_BASE : BUF_A_BASE;
                wr_length    <= FRAME_LEN;
                wr_buf_sel   <= wr_sel_nxt;
                wr_stall     <= 1'b0;
                wr_tcnt      <= 20'h0;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (wr_frame_req) begin
                            wr_state  <= W_WAIT;
                            wr_target <= ~last_complete;
                            wr_stall  <= 1'b1;
                        end
                    end
                    W_LOAD: wr_state <= W_BUSY;
                    W_BUSY: begin
                        if (wr_done) begin
                            last_complete <= wr_buf_sel;
                            frame_valid   <= 1'b1;
                            frame_cnt     <= frame_cnt + 16'd1;
                            wr_state      <= W_IDLE;
                        end else if (wr_tmo) begin
                            wr_timeout <= 1'b1;
                            wr_state   <= W_IDLE;
                        end else begin
                            wr_tcnt <= wr_tcnt + 20'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            rd_load      <= 1'b0;
            rd_frame_ack <= 1'b0;
            rd_addr      <= 24'h0;
            rd_length    <= 24'h0;
            rd_buf_sel   <= 1'b0;
            rd_lock      <= 1'b0;
            rd_tcnt      <= 20'h0;
            rd_timeout   <= 1'b0;
        end else begin
            rd_load      <= 1'b0;
            rd_frame_ack <= 1'b0;
            if (rd_go) begin
                rd_state     <= R_LOAD;
                rd_load      <= 1'b1;
                rd_frame_ack <= 1'b1;
                rd_addr      <= last_complete ? BUF_B_BASE : BUF_A_BASE;
                rd_length    <= FRAME_LEN;
                rd_buf_sel   <= last_complete;
                rd_lock      <= 1'b1;
                rd_tcnt      <= 20'h0;
            end else begin
                case (rd_state)
                    R_IDLE: if (rd_frame_req) rd_state <= R_WAIT;
                    R_LOAD: rd_state <= R_BUSY;
                    R_BUSY: begin
                        if (rd_done) begin
                            rd_lock  <= 1'b0;
                            rd_state <= R_IDLE;
                        end else if (rd_tmo) begin
                            rd_timeout <= 1'b1;
                            rd_lock    <= 1'b0;
                            rd_state   <= R_IDLE;
                        end else begin
                            rd_tcnt <= rd_tcnt + 20'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_pingpong_sched.sv
// Scoreboard bench for sdram_pingpong_sched: expected loads are queued by the
// stimulus and popped by a monitor whenever the DUT issues wr_load/rd_load.
module tb_sdram_pingpong_sched;

    localparam logic [23:0] A_BASE = 24'h000000;
    localparam logic [23:0] B_BASE = 24'h008000;
    localparam logic [23:0] F_LEN  = 24'h000800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_frame_req = 1'b0;
    logic        rd_frame_req = 1'b0;
    logic        wr_done = 1'b0;
    logic        rd_done = 1'b0;
    logic        wr_frame_ack, rd_frame_ack;
    logic        wr_load, rd_load;
    logic [23:0] wr_addr, wr_length, rd_addr, rd_length;
    logic        wr_buf_sel, rd_buf_sel, wr_stall;
    logic [15:0] frame_cnt;
    logic        wr_timeout, rd_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [23:0] addr;
        logic        sel;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];

    sdram_pingpong_sched #(.TIMEOUT(20'd100)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_frame_req (wr_frame_req),
        .wr_frame_ack (wr_frame_ack),
        .rd_frame_req (rd_frame_req),
        .rd_frame_ack (rd_frame_ack),
        .wr_load      (wr_load),
        .wr_addr      (wr_addr),
        .wr_length    (wr_length),
        .wr_done      (wr_done),
        .rd_load      (rd_load),
        .rd_addr      (rd_addr),
        .rd_length    (rd_length),
        .rd_done      (rd_done),
        .wr_buf_sel   (wr_buf_sel),
        .rd_buf_sel   (rd_buf_sel),
        .wr_stall     (wr_stall),
        .frame_cnt    (frame_cnt),
        .wr_timeout   (wr_timeout),
        .rd_timeout   (rd_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every issued command must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_load) begin
                if (wr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_load_unexpected: got addr %0h expected none", wr_addr);
                end else begin
                    exp_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_buf_sel", wr_buf_sel, e.sel);
                    chk("wr_length", wr_length, F_LEN);
                    chk("wr_ack_with_load", wr_frame_ack, 1);
                end
            end
            if (rd_load) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_load_unexpected: got addr %0h expected none", rd_addr);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_addr", rd_addr, e.addr);
                    chk("rd_buf_sel", rd_buf_sel, e.sel);
                    chk("rd_length", rd_length, F_LEN);
                    chk("rd_ack_with_load", rd_frame_ack, 1);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        wr_frame_req = 1'b0;
        rd_frame_req = 1'b0;
        wr_done = 1'b0;
        rd_done = 1'b0;
        wr_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit rd, input int bound, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rd ? rd_frame_ack : wr_frame_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1);
    endtask

    task automatic pulse_wr_done();
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    task automatic pulse_rd_done();
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    task automatic wr_frame(input logic [23:0] a, input logic s, input bit done);
        wr_q.push_back('{addr: a, sel: s});
        wr_frame_req = 1'b1;
        wait_ack(1'b0, 4, "wr_ack_seen");
        wr_frame_req = 1'b0;
        if (done) begin
            repeat (3) @(negedge clk);
            pulse_wr_done();
        end
    endtask

    task automatic rd_frame(input logic [23:0] a, input logic s, input bit done);
        rd_q.push_back('{addr: a, sel: s});
        rd_frame_req = 1'b1;
        wait_ack(1'b1, 4, "rd_ack_seen");
        rd_frame_req = 1'b0;
        if (done) begin
            repeat (3) @(negedge clk);
            pulse_rd_done();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // 1: reset state, first write to A, read back A
        do_reset();
        chk("reset_outputs",
            {wr_load, rd_load, wr_addr, rd_addr, wr_length, rd_length,
             frame_cnt, wr_stall, wr_timeout, rd_timeout},
            0);
        wr_q.push_back('{addr: A_BASE, sel: 1'b0});
        wr_frame_req = 1'b1;
        wait_ack(1'b0, 2, "first_wr_latency");
        wr_frame_req = 1'b0;
        repeat (2) @(negedge clk);
        pulse_wr_done();
        chk("frame_cnt_t1", frame_cnt, 1);
        rd_frame(A_BASE, 1'b0, 1'b1);

        // 2: read before any write waits for the first frame
        do_reset();
        rd_frame_req = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rd_frame_ack || rd_load) seen = 1'b1;
        end
        chk("rd_blocked_no_frame", seen, 0);
        rd_q.push_back('{addr: A_BASE, sel: 1'b0});
        wr_frame(A_BASE, 1'b0, 1'b1);
        wait_ack(1'b1, 2, "rd_after_first_frame");
        rd_frame_req = 1'b0;
        pulse_rd_done();

        // 3: four back-to-back writes alternate buffers
        do_reset();
        wr_frame(A_BASE, 1'b0, 1'b1);
        wr_frame(B_BASE, 1'b1, 1'b1);
        wr_frame(A_BASE, 1'b0, 1'b1);
        wr_frame(B_BASE, 1'b1, 1'b1);
        chk("frame_cnt_t3", frame_cnt, 4);
        rd_frame(B_BASE, 1'b1, 1'b1);

        // 4: write stalls on the buffer held by the reader
        do_reset();
        wr_frame(A_BASE, 1'b0, 1'b1);
        rd_frame(A_BASE, 1'b0, 1'b0);
        wr_frame(B_BASE, 1'b1, 1'b1);
        wr_q.push_back('{addr: A_BASE, sel: 1'b0});
        wr_frame_req = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_load) seen = 1'b1;
        end
        chk("stall_no_load", seen, 0);
        chk("stall_flag", wr_stall, 1);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("stall_released", wr_stall, 0);
        chk("load_after_release", wr_load, 1);
        wr_frame_req = 1'b0;
        rd_frame(B_BASE, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        pulse_wr_done();
        chk("frame_cnt_t4", frame_cnt, 3);
        pulse_rd_done();

        // 5: write timeout leaves the target buffer incomplete
        do_reset();
        wr_frame(A_BASE, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        chk("wr_timeout_early", wr_timeout, 0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (wr_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wr_timeout_set", seen, 1);
        chk("frame_cnt_t5", frame_cnt, 0);
        wr_frame(A_BASE, 1'b0, 1'b1);
        chk("frame_cnt_t5b", frame_cnt, 1);
        chk("wr_timeout_sticky", wr_timeout, 1);

        // 6: asynchronous reset mid-transfer
        do_reset();
        wr_frame(A_BASE, 1'b0, 1'b1);
        wr_frame(B_BASE, 1'b1, 1'b0);
        rd_frame(A_BASE, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {wr_load, rd_load, wr_addr, rd_addr, wr_length, rd_length,
             frame_cnt, wr_buf_sel, rd_buf_sel, wr_stall, wr_timeout,
             rd_timeout, wr_frame_ack, rd_frame_ack},
            0);
        @(negedge clk);
        rst = 1'b0;
        wr_frame(A_BASE, 1'b0, 1'b1);
        chk("frame_cnt_t6", frame_cnt, 1);

        repeat (3) @(negedge clk);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_pingpong_sched.md
Name: sdram_pingpong_sched

Overview:
- Double-buffer frame scheduler in front of the sdram_mcb write/read command ports.
- A frame producer (camera/host) and a frame consumer (VGA scan-out) each request whole frames. The block picks buffer A or B and issues wr_load/rd_load with base address and length.
- Guarantees the consumer always gets the most recent complete frame and never sees a buffer being overwritten.

Parameters:
BUF_A_BASE  24'h000000  base word address of buffer A ({Bank,Row,Col})
BUF_B_BASE  24'h008000  base word address of buffer B
FRAME_LEN   24'h000800  words per frame; driven unchanged on wr_length/rd_length
TIMEOUT     20'hFFFFF   max cycles from load to done before abort

Ports:
clk            in   1   system clock (sdram_mcb clk_wr/clk_rd domain)
rst            in   1   asynchronous reset, active-high
wr_frame_req   in   1   producer requests a frame write; level, held until ack
wr_frame_ack   out  1   one-cycle pulse, coincident with wr_load
rd_frame_req   in   1   consumer requests a frame read; level, held until ack
rd_frame_ack   out  1   one-cycle pulse, coincident with rd_load
wr_load        out  1   to mcb: start write command
wr_addr        out  24  to mcb: write base address
wr_length      out  24  to mcb: write length
wr_done        in   1   from mcb: write complete pulse
rd_load        out  1   to mcb: start read command
rd_addr        out  24  to mcb: read base address
rd_length      out  24  to mcb: read length
rd_done        in   1   from mcb: read complete pulse
wr_buf_sel     out  1   buffer of current/last write (0=A, 1=B)
rd_buf_sel     out  1   buffer of current/last read
wr_stall       out  1   write request pending, blocked by active read
frame_cnt      out  16  completed write frames, wraps 16'hFFFF->0
wr_timeout     out  1   sticky: write done not seen within TIMEOUT
rd_timeout     out  1   sticky: read done not seen within TIMEOUT

Behaviour:
- All outputs are registered.
- Reset (async, immediate):
  - Write and read FSMs go to IDLE.
  - All pulses, addresses, lengths and frame_cnt = 0; wr_timeout = rd_timeout = 0.
  - last_complete = 1, so the first write targets A; frame_valid = 0; rd_lock = 0.
- Write FSM: W_IDLE, W_WAIT, W_LOAD, W_BUSY.
  - W_IDLE, wr_frame_req=1: target = ~last_complete.
    - If rd_lock=1 and rd_buf_sel==target: go W_WAIT.
    - Otherwise: go W_LOAD.
  - W_WAIT: wr_stall=1. Leave for W_LOAD on the first cycle rd_lock clears (rd_done or rd timeout).
  - W_LOAD (one cycle): wr_load=1 and wr_frame_ack=1; wr_addr = base of target, wr_length = FRAME_LEN, wr_buf_sel = target. Then go W_BUSY.
    - Latency: request sampled at edge N drives wr_load during cycle N+1 when no stall.
    - wr_addr and wr_length hold until the next load.
  - W_BUSY on wr_done: last_complete <= wr_buf_sel, frame_valid <= 1, frame_cnt++, then W_IDLE.
  - W_BUSY timeout: counter reaches TIMEOUT with no done → wr_timeout <= 1 and go W_IDLE. Buffer not marked complete; frame_cnt unchanged.
- Read FSM: R_IDLE, R_WAIT, R_LOAD, R_BUSY.
  - R_IDLE, rd_frame_req=1: go R_LOAD if frame_valid, otherwise R_WAIT.
  - R_WAIT: go R_LOAD the cycle after frame_valid becomes 1.
  - R_LOAD (one cycle): rd_load=1 and rd_frame_ack=1; rd_addr = base of last_complete (registered value), rd_length = FRAME_LEN, rd_buf_sel = last_complete, rd_lock <= 1. Then go R_BUSY.
  - R_BUSY on rd_done: rd_lock <= 0, then R_IDLE.
  - R_BUSY timeout: rd_timeout <= 1, rd_lock <= 0, then R_IDLE.
- Simultaneous events:
  - wr_done in the same cycle R_IDLE samples rd_frame_req: the read uses the pre-update last_complete (old frame).
  - rd_done and a stalled write in the same cycle: the write proceeds to W_LOAD at the next edge.
  - wr_load and rd_load may assert in the same cycle (mcb arbitrates internally).
- Repeated reads without new writes re-read the same last_complete buffer.
- wr_done/rd_done outside BUSY are ignored.
- Timeout counters are 20 bits, cleared on every load, and count only in BUSY.
- Sticky timeout flags clear only on reset.

Test Plan:
1. Reset, wr_frame_req=1: wr_load pulse at the 2nd edge with wr_addr=000000, wr_length=000800, wr_buf_sel=0. Pulse wr_done: frame_cnt=1. Then rd_frame_req: rd_load with rd_addr=000000.
2. rd_frame_req before any write: no rd_load, rd FSM in R_WAIT. After first wr_done: rd_load within 2 cycles, rd_addr=000000, rd_frame_ack coincident.
3. Four back-to-back write frames, no reads: wr_addr sequence 000000, 008000, 000000, 008000; frame_cnt=4; last_complete=1.
4. Stall case:
   - Write A, start read of A (no rd_done), write B completes, request a third write.
   - Required: wr_stall=1 and no wr_load.
   - Pulse rd_done: wr_stall drops and wr_load fires with wr_addr=000000 one cycle later.
   - A new rd_frame_req reads 008000.
5. Timeout with TIMEOUT=20'd100: issue a write and withhold wr_done → wr_timeout=1 after 100 BUSY cycles, frame_cnt unchanged, FSM back in W_IDLE. The next write still targets the same buffer.
6. Assert rst mid-W_BUSY and mid-R_BUSY, asynchronous to clk: all outputs return to reset values immediately. After release, the first write targets 000000.
